ascii_frame_serializer: RTL and testbench

Takes the four ASCII digit bytes of one decoded 12-bit sample and emits them as a byte stream, followed by a delimiter, towards the USB FIFO write stage. It sits directly downstream of the binary-to-ASCII digit splitter and upstream of the USB FIFO transmit logic. A valid/ready handshake is used on both sides. Each accepted sample produces exactly one frame, with optional leading-zero suppression.

---
 rtl/usb_ascii_pkg.sv | 16 +
 rtl/ascii_frame_serializer.sv | 119 +++++++++++
 tb/tb_ascii_frame_serializer.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/usb_ascii_pkg.sv
// Shared ASCII constants and serializer state encoding for the USB sample-to-text path.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package usb_ascii_pkg;

   localparam logic [7:0] ASCII_ZERO  = 8'h30;
   localparam logic [7:0] ASCII_LF    = 8'h0A;
   localparam logic [7:0] ASCII_COMMA = 8'h2C;

   typedef enum logic [1:0] {
      IDLE,
      DIGIT,
      DELIM
   } ser_state_t;

endpackage

// File: rtl/ascii_frame_serializer.sv
// Serializes one sample's four ASCII digits plus a delimiter byte into a byte stream.
// Latency: first byte valid the cycle after input accept; one byte per out_ready edge; 1 idle cycle between frames.
// Backpressure: out_data/out_valid held while out_ready is low; in_ready low until the delimiter is taken.
//
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   in_valid/in_ready          - sample handshake; digits latched on transfer
//   thousands..ones            - ASCII digit bytes (passed through unchanged)
//   out_data/out_valid/out_ready - byte stream towards the USB FIFO write stage
//   frame_done                 - one-cycle pulse after the delimiter is accepted
//   frames_sent                - completed frame count, wraps at 2^CNT_W
module ascii_frame_serializer
   import usb_ascii_pkg::ser_state_t,
          usb_ascii_pkg::IDLE,
          usb_ascii_pkg::DIGIT,
          usb_ascii_pkg::ASCII_ZERO,
          usb_ascii_pkg::ASCII_LF;
#(
   parameter logic [7:0] DELIM       = ASCII_LF,
   parameter bit         SUPPRESS_LZ = 1'b0,
   parameter int         CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       thousands,
   input  logic [7:0]       hundreds,
   input  logic [7:0]       tens,
   input  logic [7:0]       ones,
   output logic [7:0]       out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             frame_done,
   output logic [CNT_W-1:0] frames_sent
);

   // The delimiter state label is named explicitly because the DELIM
   // parameter owns the bare name inside this module.
   ser_state_t       state_q, state_d;
   logic [1:0]       idx_q, idx_d;
   // Index 0 is the thousands digit, index 3 the ones digit.
   logic [3:0][7:0]  dig_q, dig_d;
   logic             done_d;
   logic [CNT_W-1:0] cnt_d;
   logic [7:0]       data_d;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      dig_d   = dig_q;
      done_d  = 1'b0;
      cnt_d   = frames_sent;
      data_d  = 8'h00;

      case (state_q)
         IDLE: begin
            if (in_valid && in_ready) begin
               dig_d   = {ones, tens, hundreds, thousands};
               state_d = DIGIT;
               idx_d   = 2'd0;
               if (SUPPRESS_LZ) begin
                  // The ones digit is always sent, so only the upper three
                  // positions take part in zero skipping.
                  if (thousands != ASCII_ZERO)     idx_d = 2'd0;
                  else if (hundreds != ASCII_ZERO) idx_d = 2'd1;
                  else if (tens != ASCII_ZERO)     idx_d = 2'd2;
                  else                             idx_d = 2'd3;
               end
            end
         end
         DIGIT: begin
            if (out_ready) begin
               if (idx_q == 2'd3) state_d = usb_ascii_pkg::DELIM;
               else               idx_d   = idx_q + 2'd1;
            end
         end
         usb_ascii_pkg::DELIM: begin
            if (out_ready) begin
               state_d = IDLE;
               done_d  = 1'b1;
               cnt_d   = frames_sent + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      // Output byte is derived from the next state so the registered
      // out_data lines up with out_valid on the following cycle.
      case (state_d)
         DIGIT:                data_d = dig_d[idx_d];
         usb_ascii_pkg::DELIM: data_d = DELIM;
         default:              data_d = 8'h00;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         idx_q       <= 2'd0;
         dig_q       <= '0;
         in_ready    <= 1'b1;
         out_valid   <= 1'b0;
         out_data    <= 8'h00;
         frame_done  <= 1'b0;
         frames_sent <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         dig_q       <= dig_d;
         in_ready    <= (state_d == IDLE);
         out_valid   <= (state_d != IDLE);
         out_data    <= data_d;
         frame_done  <= done_d;
         frames_sent <= cnt_d;
      end
   end

endmodule

// File: tb/tb_ascii_frame_serializer.sv
// Bench for ascii_frame_serializer: one instance without zero suppression and a
// 4-bit counter, one with zero suppression; a shared stimulus bus is steered by sel.
// Expected bytes come from a formatting model of the digit/delimiter rules.
module tb_ascii_frame_serializer;

   logic        clk = 1'b0;
   logic        reset;
   logic        sel;
   logic        in_valid;
   logic        out_ready;
   logic [7:0]  d_th, d_hu, d_te, d_on;

   logic        ir0, ov0, fd0, ir1, ov1, fd1;
   logic [7:0]  od0, od1;
   logic [3:0]  fs0;
   logic [15:0] fs1;

   logic        obs_ir, obs_vld, obs_fd;
   logic [7:0]  obs_data;
   logic [15:0] obs_fs;

   int          total  = 0;
   int          passed = 0;
   int          cnt [2];
   logic [7:0]  exp_q [$];
   int          pat [$];

   always #5 clk = ~clk;

   ascii_frame_serializer #(.DELIM(8'h0A), .SUPPRESS_LZ(1'b0), .CNT_W(4)) u0 (
      .clk(clk), .reset(reset),
      .in_valid(in_valid && !sel), .in_ready(ir0),
      .thousands(d_th), .hundreds(d_hu), .tens(d_te), .ones(d_on),
      .out_data(od0), .out_valid(ov0), .out_ready(out_ready && !sel),
      .frame_done(fd0), .frames_sent(fs0));

   ascii_frame_serializer #(.DELIM(8'h0A), .SUPPRESS_LZ(1'b1), .CNT_W(16)) u1 (
      .clk(clk), .reset(reset),
      .in_valid(in_valid && sel), .in_ready(ir1),
      .thousands(d_th), .hundreds(d_hu), .tens(d_te), .ones(d_on),
      .out_data(od1), .out_valid(ov1), .out_ready(out_ready && sel),
      .frame_done(fd1), .frames_sent(fs1));

   assign obs_ir   = sel ? ir1 : ir0;
   assign obs_vld  = sel ? ov1 : ov0;
   assign obs_fd   = sel ? fd1 : fd0;
   assign obs_data = sel ? od1 : od0;
   assign obs_fs   = sel ? fs1 : {12'h000, fs0};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
   endtask

   task automatic timeout(input string tag);
      total++;
      $error("FAIL %s: observed no progress expected handshake", tag);
   endtask

   function automatic logic [31:0] asc4(input int v);
      return {8'(8'h30 + (v / 1000) % 10), 8'(8'h30 + (v / 100) % 10),
              8'(8'h30 + (v / 10) % 10),   8'(8'h30 + v % 10)};
   endfunction

   // Zero-heavy digit bytes, with the odd arbitrary byte to exercise pass-through.
   function automatic logic [7:0] rnd_dig();
      int r;
      r = $urandom_range(0, 9);
      if (r < 4)  return 8'h30;
      if (r == 9) return 8'($urandom_range(0, 255));
      return 8'(8'h30 + $urandom_range(1, 9));
   endfunction

   function automatic logic [31:0] rnd4();
      return {rnd_dig(), rnd_dig(), rnd_dig(), rnd_dig()};
   endfunction

   // Reference frame: digits from the first one worth printing, then LF.
   task automatic build(input logic [31:0] digs, input bit lz);
      logic [7:0] b [4];
      int first;
      b[0] = digs[31:24]; b[1] = digs[23:16]; b[2] = digs[15:8]; b[3] = digs[7:0];
      exp_q.delete();
      first = 0;
      if (lz) while (first < 3 && b[first] == 8'h30) first++;
      for (int i = first; i < 4; i++) exp_q.push_back(b[i]);
      exp_q.push_back(8'h0A);
   endtask

   // mode: 0 = out_ready always high, 1 = random, 2 = pattern queue then high.
   // churn keeps in_valid high with changing digits during the frame and
   // presents next_digs in the first idle cycle; pre means digits are
   // already presented at the current falling edge with in_ready seen high.
   task automatic do_frame(input logic [31:0] digs, input int mode, input bit churn,
                           input bit pre, input logic [31:0] next_digs);
      int guard;
      int pidx;
      bit hold;
      logic [7:0] held;
      build(digs, sel);
      if (!pre) begin
         guard = 0;
         forever begin
            @(negedge clk);
            in_valid = 1'b1;
            {d_th, d_hu, d_te, d_on} = digs;
            if (obs_ir) break;
            guard++;
            if (guard > 20) begin
               timeout("accept");
               in_valid = 1'b0;
               return;
            end
         end
      end
      @(posedge clk);
      @(negedge clk);
      in_valid = churn;
      {d_th, d_hu, d_te, d_on} = rnd4();
      check("first_vld", obs_vld, 1);
      hold = 1'b0;
      held = 8'h00;
      pidx = 0;
      guard = 0;
      while (exp_q.size() > 0) begin
         if (mode == 0)      out_ready = 1'b1;
         else if (mode == 2) out_ready = (pidx < pat.size()) ? pat[pidx][0] : 1'b1;
         else                out_ready = 1'($urandom_range(0, 1));
         pidx++;
         check("busy_in_ready", obs_ir, 0);
         check("busy_vld", obs_vld, 1);
         check("busy_done", obs_fd, 0);
         if (hold) check("hold_data", obs_data, held);
         if (out_ready) begin
            check("byte", obs_data, exp_q.pop_front());
            hold = 1'b0;
         end else begin
            hold = 1'b1;
            held = obs_data;
         end
         guard++;
         if (guard > 60) begin
            timeout("frame");
            break;
         end
         @(negedge clk);
         if (churn) {d_th, d_hu, d_te, d_on} = rnd4();
      end
      cnt[sel]++;
      check("frame_done", obs_fd, 1);
      check("idle_in_ready", obs_ir, 1);
      check("idle_vld", obs_vld, 0);
      check("frames_sent", obs_fs, sel ? (cnt[1] % 65536) : (cnt[0] % 16));
      if (churn) {d_th, d_hu, d_te, d_on} = next_digs;
      else       in_valid = 1'b0;
   endtask

   initial begin
      logic [31:0] none;
      none = 32'h0;
      reset = 1'b1; sel = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      {d_th, d_hu, d_te, d_on} = asc4(0);
      cnt[0] = 0; cnt[1] = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      for (int s = 0; s < 2; s++) begin
         sel = 1'(s);
         #1;
         check("rst_in_ready", obs_ir, 1);
         check("rst_vld", obs_vld, 0);
         check("rst_data", obs_data, 8'h00);
         check("rst_done", obs_fd, 0);
         check("rst_frames", obs_fs, 0);
      end

      // Zero suppression instance: directed corner cases, then random frames.
      sel = 1'b1;
      do_frame(asc4(7), 0, 0, 0, none);
      do_frame(asc4(0), 0, 0, 0, none);
      do_frame(asc4(405), 0, 0, 0, none);
      for (int i = 0; i < 20; i++) do_frame(rnd4(), 1, 0, 0, none);

      // Full-width instance.
      sel = 1'b0;
      do_frame(asc4(1234), 0, 0, 0, none);
      do_frame(asc4(7), 0, 0, 0, none);
      pat = '{1, 0, 0, 1, 0, 1, 1, 1};
      do_frame(asc4(4095), 2, 0, 0, none);
      do_frame(asc4(2718), 0, 1, 0, asc4(3141));
      do_frame(asc4(3141), 1, 0, 1, none);

      // Reset while byte 33 of 1234 is on the output.
      @(negedge clk);
      in_valid = 1'b1;
      {d_th, d_hu, d_te, d_on} = asc4(1234);
      check("mid_pre_ready", obs_ir, 1);
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b1;
      check("mid_b0", obs_data, 8'h31);
      @(negedge clk);
      check("mid_b1", obs_data, 8'h32);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      cnt[0] = 0; cnt[1] = 0;
      check("mid_rst_vld", obs_vld, 0);
      check("mid_rst_ready", obs_ir, 1);
      check("mid_rst_frames", obs_fs, 0);
      do_frame(asc4(999), 0, 0, 0, none);

      // 16 more frames on the 4-bit counter: passes through 15, 0, 1.
      for (int i = 0; i < 16; i++) do_frame(rnd4(), 1, 0, 0, none);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
